// File: rtl/maxpool_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_frame_ctrl
// Description : Frame sequencer wrapped around an external 8-channel 2x2
//               max-pooling layer. It gates WIDTH*HEIGHT source pixels into
//               the pooling layer and registers the (WIDTH/2)*(HEIGHT/2)
//               results to the output. It flags the last result, waits a
//               bounded time for stragglers and reports timeout and overrun
//               errors.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start             - begin one frame (honoured only in IDLE)
//               src_valid/data    - upstream pixel stream (bit k = channel k)
//               src_ready         - pixel accepted (high only in FEED)
//               pool_valid_in/px  - zero-latency pixel strobe to pooling layer
//               pool_valid_out/d  - pooling-layer result strobe
//               out_valid/data    - registered result, out_last on final one
//               busy, done        - FEED/DRAIN indicator, one-cycle DONE pulse
//               err_timeout       - DRAIN ran out of idle budget (sticky)
//               err_overrun       - unexpected pooling result (sticky)
//               in_cnt, out_cnt   - accepted pixels / delivered results
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool_frame_ctrl #(
    parameter int WIDTH         = 26,
    parameter int HEIGHT        = 26,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       src_valid,
    input  logic [7:0] src_data,
    output logic       src_ready,
    output logic       pool_valid_in,
    output logic [7:0] pool_pixel,
    input  logic       pool_valid_out,
    input  logic [7:0] pool_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic       done,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic [9:0] in_cnt,
    output logic [9:0] out_cnt
);

    localparam int N_IN  = WIDTH * HEIGHT;
    localparam int N_OUT = (WIDTH / 2) * (HEIGHT / 2);
    localparam int TO_W  = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [9:0]      c_N_IN     = 10'(N_IN);
    localparam logic [9:0]      c_IN_LAST  = 10'(N_IN - 1);
    localparam logic [9:0]      c_N_OUT    = 10'(N_OUT);
    localparam logic [9:0]      c_OUT_LAST = 10'(N_OUT - 1);
    localparam logic [TO_W-1:0] c_TO_LAST  = TO_W'(DRAIN_TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FEED  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [9:0]      r_in_cnt;
    logic [9:0]      r_out_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_out_valid;
    logic [7:0]      r_out_data;
    logic            r_out_last;
    logic            r_err_timeout;
    logic            r_err_overrun;

    logic w_start;
    logic w_accept;
    logic w_res_ok;
    logic w_overrun;
    logic w_all_out;
    logic w_to_expire;

    assign w_start   = (r_state == c_ST_IDLE) & start;
    assign w_accept  = src_valid & src_ready;
    assign w_all_out = (r_out_cnt == c_N_OUT);
    // A result is only legal while a frame is open and not yet complete;
    // anything else is an overrun and never reaches the output.
    assign w_res_ok  = pool_valid_out & ~w_all_out &
                       ((r_state == c_ST_FEED) | (r_state == c_ST_DRAIN));
    assign w_overrun = pool_valid_out & ~w_res_ok;
    // Normal completion takes precedence over a coincident timeout.
    assign w_to_expire = (r_state == c_ST_DRAIN) & ~pool_valid_out &
                         ~w_all_out & (r_to_cnt == c_TO_LAST);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_next_state = c_ST_FEED;
            c_ST_FEED:  if (w_accept && (r_in_cnt == c_IN_LAST)) w_next_state = c_ST_DRAIN;
            c_ST_DRAIN: if (w_all_out || w_to_expire) w_next_state = c_ST_DONE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        src_ready     = (r_state == c_ST_FEED);
        busy          = (r_state == c_ST_FEED) | (r_state == c_ST_DRAIN);
        done          = (r_state == c_ST_DONE);
        pool_valid_in = w_accept;
        pool_pixel    = src_data;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_cnt      <= '0;
            r_out_cnt     <= '0;
            r_to_cnt      <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_last    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_out_valid <= w_res_ok;
            r_out_last  <= w_res_ok & (r_out_cnt == c_OUT_LAST);
            if (w_res_ok) begin
                r_out_data <= pool_data;
            end
            // An overrun seen in the same cycle as start is still reported.
            r_err_overrun <= w_overrun | (r_err_overrun & ~w_start);

            if (w_start) begin
                r_in_cnt      <= '0;
                r_out_cnt     <= '0;
                r_to_cnt      <= '0;
                r_err_timeout <= 1'b0;
            end else begin
                if (w_accept && (r_in_cnt != c_N_IN)) begin
                    r_in_cnt <= r_in_cnt + 10'd1;
                end
                if (w_res_ok) begin
                    r_out_cnt <= r_out_cnt + 10'd1;
                end
                // Idle-cycle counter restarts on every result seen in DRAIN.
                if (r_state == c_ST_DRAIN) begin
                    r_to_cnt <= pool_valid_out ? '0 : r_to_cnt + 1'b1;
                end
                if (w_to_expire) begin
                    r_err_timeout <= 1'b1;
                end
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;
    assign err_timeout = r_err_timeout;
    assign err_overrun = r_err_overrun;
    assign in_cnt      = r_in_cnt;
    assign out_cnt     = r_out_cnt;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxpool_frame_ctrl
// Description : Self-checking bench for maxpool_frame_ctrl. A behavioural
//               2x2 OR-pooling layer (1-bit channels, so max == OR) answers
//               the DUT's pixel strobes; expected results are computed from
//               the generated frame and queued, then popped as the DUT
//               delivers them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool_frame_ctrl;

    localparam int W     = 26;
    localparam int H     = 26;
    localparam int TO    = 64;
    localparam int N_IN  = W * H;
    localparam int N_OUT = (W / 2) * (H / 2);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic       pool_valid_in;
    logic [7:0] pool_pixel;
    logic       pool_valid_out;
    logic [7:0] pool_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic       err_overrun;
    logic [9:0] in_cnt;
    logic [9:0] out_cnt;

    maxpool_frame_ctrl #(
        .WIDTH         (W),
        .HEIGHT        (H),
        .DRAIN_TIMEOUT (TO)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .pool_valid_in  (pool_valid_in),
        .pool_pixel     (pool_pixel),
        .pool_valid_out (pool_valid_out),
        .pool_data      (pool_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done),
        .err_timeout    (err_timeout),
        .err_overrun    (err_overrun),
        .in_cnt         (in_cnt),
        .out_cnt        (out_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pix  [0:N_IN-1];
    logic [7:0] mbuf [0:N_IN-1];
    int         n_vec    = 0;
    int         n_err    = 0;
    int         cyc_cnt  = 0;
    int         n_last   = 0;
    int         last_cyc = 0;
    int         m_limit  = N_OUT;
    logic       inject   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Behavioural pooling layer: one-cycle result latency after the
    // bottom-right pixel of each 2x2 window, optionally truncated at m_limit.
    int   m_idx = 0;
    int   m_res = 0;
    always @(posedge clk) begin
        logic hit;
        hit = 1'b0;
        if (rst || (start && !busy)) begin
            m_idx = 0;
            m_res = 0;
            pool_valid_out <= 1'b0;
            pool_data      <= 8'h00;
        end else begin
            if (pool_valid_in && m_idx < N_IN) begin
                mbuf[m_idx] = pool_pixel;
                if (((m_idx / W) % 2 == 1) && ((m_idx % W) % 2 == 1) && m_res < m_limit) begin
                    pool_data <= mbuf[m_idx] | mbuf[m_idx-1] | mbuf[m_idx-W] | mbuf[m_idx-W-1];
                    hit = 1'b1;
                    m_res++;
                end
                m_idx++;
            end
            pool_valid_out <= hit | inject;
        end
    end

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_data", out_data, e.d);
                check_eq("out_last", out_last, e.l);
            end
        end
        if (out_last === 1'b1) begin
            n_last++;
            last_cyc = cyc_cnt;
        end
    end

    task automatic run_frame(input int limit, input bit toggle, input int abort_at,
                             input int start_at, input string nm);
        int   sent;
        int   guard;
        int   drain_cyc;
        int   done_cyc;
        int   last0;
        bit   chk_start;
        logic [7:0] e;
        exp_t ent;

        for (int i = 0; i < N_IN; i++) pix[i] = 8'($urandom);
        for (int r = 0; r < H / 2; r++) begin
            for (int c = 0; c < W / 2; c++) begin
                int i;
                i = (2 * r) * W + 2 * c;
                e = pix[i] | pix[i+1] | pix[i+W] | pix[i+W+1];
                if (r * (W / 2) + c < limit) begin
                    ent.d = e;
                    ent.l = (r * (W / 2) + c == N_OUT - 1);
                    exp_q.push_back(ent);
                end
            end
        end
        m_limit = limit;
        last0   = n_last;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        check_eq({nm, "_busy_after_start"}, busy, 1);
        check_eq({nm, "_in_cnt_clr"}, in_cnt, 0);
        check_eq({nm, "_out_cnt_clr"}, out_cnt, 0);
        check_eq({nm, "_err_ovr_clr"}, err_overrun, 0);
        check_eq({nm, "_err_to_clr"}, err_timeout, 0);

        sent = 0; guard = 0; chk_start = 1'b0;
        while (sent < N_IN && guard < 4 * N_IN) begin
            @(negedge clk);
            start = 1'b0;
            if (abort_at > 0 && sent == abort_at) begin
                check_eq({nm, "_in_cnt_pre_rst"}, in_cnt, sent);
                rst = 1'b1; start = 1'b1; src_valid = 1'b1;
                @(negedge clk); #1;
                check_eq({nm, "_rst_busy"}, busy, 0);
                check_eq({nm, "_rst_ready"}, src_ready, 0);
                check_eq({nm, "_rst_in_cnt"}, in_cnt, 0);
                check_eq({nm, "_rst_out_cnt"}, out_cnt, 0);
                check_eq({nm, "_rst_out_valid"}, out_valid, 0);
                rst = 1'b0; start = 1'b0; src_valid = 1'b0;
                exp_q.delete();
                return;
            end
            if (chk_start) begin
                check_eq({nm, "_start_ignored_in_cnt"}, in_cnt, sent);
                check_eq({nm, "_start_ignored_busy"}, busy, 1);
                chk_start = 1'b0;
            end
            src_valid = toggle ? (guard % 2 == 1) : 1'b1;
            src_data  = pix[sent];
            if (start_at > 0 && sent == start_at) begin
                start = 1'b1;
                chk_start = 1'b1;
            end
            #1;
            check_eq({nm, "_ready_feed"}, src_ready, 1);
            check_eq({nm, "_pv_in"}, pool_valid_in, src_valid);
            if (src_valid) begin
                check_eq({nm, "_pool_px"}, pool_pixel, pix[sent]);
                sent++;
            end
            guard++;
        end
        check_eq({nm, "_feed_complete"}, sent, N_IN);

        @(negedge clk); src_valid = 1'b0; start = 1'b0; #1;
        check_eq({nm, "_ready_low_drain"}, src_ready, 0);
        check_eq({nm, "_pv_in_drain"}, pool_valid_in, 0);
        check_eq({nm, "_in_cnt_full"}, in_cnt, N_IN);
        drain_cyc = busy ? 1 : 0;
        done_cyc  = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (done) begin
                done_cyc = cyc_cnt;
                break;
            end
            if (busy) drain_cyc++;
        end
        check_eq({nm, "_done_seen"}, (done_cyc >= 0), 1);
        check_eq({nm, "_out_cnt"}, out_cnt, limit);
        check_eq({nm, "_in_cnt_done"}, in_cnt, N_IN);
        check_eq({nm, "_err_overrun"}, err_overrun, 0);
        check_eq({nm, "_busy_done"}, busy, 0);
        if (limit < N_OUT) begin
            check_eq({nm, "_err_timeout"}, err_timeout, 1);
            check_eq({nm, "_drain_idle_cycles"}, drain_cyc, TO);
            check_eq({nm, "_no_out_last"}, n_last - last0, 0);
        end else begin
            check_eq({nm, "_err_timeout"}, err_timeout, 0);
            check_eq({nm, "_one_out_last"}, n_last - last0, 1);
            check_eq({nm, "_done_after_last"}, done_cyc - last_cyc, 1);
        end
        @(negedge clk); #1;
        check_eq({nm, "_done_one_cycle"}, done, 0);
        check_eq({nm, "_idle_busy"}, busy, 0);
        check_eq({nm, "_queue_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_src_ready", src_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err_timeout", err_timeout, 0);
        check_eq("rst_err_overrun", err_overrun, 0);
        check_eq("rst_in_cnt", in_cnt, 0);
        check_eq("rst_out_cnt", out_cnt, 0);
        check_eq("rst_pool_valid_in", pool_valid_in, 0);
        @(negedge clk); rst = 1'b0;

        run_frame(N_OUT,     1'b0, 0,   0,   "full");
        run_frame(N_OUT,     1'b1, 0,   0,   "toggle");
        run_frame(N_OUT - 1, 1'b0, 0,   0,   "timeout");
        run_frame(N_OUT,     1'b0, 300, 0,   "abort");
        run_frame(N_OUT,     1'b0, 0,   0,   "post_rst");
        run_frame(N_OUT,     1'b0, 0,   100, "start_busy");

        @(negedge clk); inject = 1'b1;
        @(negedge clk); inject = 1'b0;
        @(negedge clk); #1;
        check_eq("idle_overrun_flag", err_overrun, 1);
        check_eq("idle_overrun_no_out", out_valid, 0);
        check_eq("idle_overrun_busy", busy, 0);

        run_frame(N_OUT,     1'b0, 0,   0,   "after_ovr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
